// File: rtl/alu_pkg.sv
// Shared opcode constants and scheduler FSM encoding for the two-requester ALU.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // mul and div are the multi-cycle ops; both share opcode bit 1
   function automatic logic is_iter_op(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: shift-add multiply and restoring divide, one step per cycle.
module alu_iter_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] f,
   output logic             carry,
   output logic             dz
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic               busy_q;
   logic [1:0]         op_q;
   logic               dz_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [WIDTH-1:0]   opnd_q;

   logic [WIDTH:0]     sum_w;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     trial;
   logic               ge;
   logic [WIDTH-1:0]   rem_new;

   // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
   always_comb begin
      sum_w     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
      rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
      trial     = rem_shift - {1'b0, opnd_q};
      ge        = (rem_shift >= {1'b0, opnd_q});
      rem_new   = ge ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      if (op_q == OP_MUL)
         acc_d = {sum_w, acc_q[WIDTH-1:1]};
      else
         acc_d = {rem_new, acc_q[WIDTH-2:0], ge};
   end

   // Results are taken from the post-step value so the final step's edge can latch them directly
   always_comb begin
      done  = busy_q && (((op_q == OP_DIV) && dz_q) || (cnt_q == LAST));
      f     = ((op_q == OP_DIV) && dz_q) ? '0 : acc_d[WIDTH-1:0];
      carry = (op_q == OP_MUL) && (|acc_d[2*WIDTH-1:WIDTH]);
      dz    = (op_q == OP_DIV) && dz_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         op_q   <= OP_MUL;
         dz_q   <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         opnd_q <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         op_q   <= op;
         cnt_q  <= '0;
         dz_q   <= (op == OP_DIV) && (b == '0);
         if (op == OP_MUL) begin
            acc_q  <= {{WIDTH{1'b0}}, b};
            opnd_q <= a;
         end else begin
            acc_q  <= {{WIDTH{1'b0}}, a};
            opnd_q <= b;
         end
      end else if (busy_q) begin
         acc_q <= acc_d;
         if (done) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_sched.sv
// Two-requester round-robin ALU scheduler: arbitrates, executes one command at a time,
// and holds the result until the consumer takes it.
module alu_sched
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [3:0]         req_op,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [WIDTH-1:0]   rsp_f,
   output logic               rsp_carry,
   output logic               rsp_zero,
   output logic               rsp_dz
);

   state_t           state_q;
   logic             last_grant_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             id_q;

   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_f_q;
   logic             rsp_carry_q;
   logic             rsp_zero_q;
   logic             rsp_dz_q;

   logic [1:0]       grant;
   logic             accept;
   logic             sel;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   logic             core_done;
   logic [WIDTH-1:0] core_f;
   logic             core_carry;
   logic             core_dz;

   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   logic [WIDTH-1:0] exec_f;
   logic             exec_carry;
   logic             exec_dz;
   logic             exec_last;

   // On a tie the requester that did not win last time is served
   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   assign req_ready = (rst_n && (state_q == ST_IDLE)) ? grant : 2'b00;
   assign accept    = |(req_valid & req_ready);
   assign sel       = req_ready[1];
   assign sel_op    = sel ? req_op[3:2] : req_op[1:0];
   assign sel_a     = sel ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
   assign sel_b     = sel ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

   alu_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept && is_iter_op(sel_op)),
      .op    (sel_op),
      .a     (sel_a),
      .b     (sel_b),
      .done  (core_done),
      .f     (core_f),
      .carry (core_carry),
      .dz    (core_dz)
   );

   // add/sub finish in their single EXEC cycle; mul/div wait for the core
   always_comb begin
      add_w      = {1'b0, a_q} + {1'b0, b_q};
      sub_w      = {1'b0, a_q} - {1'b0, b_q};
      exec_f     = core_f;
      exec_carry = core_carry;
      exec_dz    = core_dz;
      exec_last  = core_done;
      case (op_q)
         OP_ADD: begin
            exec_f     = add_w[WIDTH-1:0];
            exec_carry = add_w[WIDTH];
            exec_dz    = 1'b0;
            exec_last  = 1'b1;
         end
         OP_SUB: begin
            exec_f     = sub_w[WIDTH-1:0];
            exec_carry = sub_w[WIDTH];
            exec_dz    = 1'b0;
            exec_last  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         op_q         <= OP_ADD;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_f_q      <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_zero_q   <= 1'b0;
         rsp_dz_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q         <= sel_op;
                  a_q          <= sel_a;
                  b_q          <= sel_b;
                  id_q         <= sel;
                  last_grant_q <= sel;
                  state_q      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (exec_last) begin
                  rsp_f_q     <= exec_f;
                  rsp_carry_q <= exec_carry;
                  rsp_zero_q  <= (exec_f == '0);
                  rsp_dz_q    <= exec_dz;
                  rsp_id_q    <= id_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_f     = rsp_f_q;
   assign rsp_carry = rsp_carry_q;
   assign rsp_zero  = rsp_zero_q;
   assign rsp_dz    = rsp_dz_q;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed cases, randomized commands against an
// arithmetic reference model, arbitration, back-pressure and asynchronous reset.
module tb_alu_sched;

   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [1:0]     req_valid = 2'b00;
   logic [1:0]     req_ready;
   logic [3:0]     req_op = 4'h0;
   logic [2*W-1:0] req_a = '0;
   logic [2*W-1:0] req_b = '0;
   logic           rsp_valid;
   logic           rsp_ready = 1'b0;
   logic           rsp_id;
   logic [W-1:0]   rsp_f;
   logic           rsp_carry;
   logic           rsp_zero;
   logic           rsp_dz;

   int n_checks = 0;
   int n_fail   = 0;
   int model_last = 1;

   always #5 clk = ~clk;

   alu_sched #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_f     (rsp_f),
      .rsp_carry (rsp_carry),
      .rsp_zero  (rsp_zero),
      .rsp_dz    (rsp_dz)
   );

   // Reference: results from plain integer arithmetic, latency from the op class
   function automatic void ref_model(input int op, input int a, input int b,
                                     output int f, output int c, output int z,
                                     output int dz, output int lat);
      int p;
      dz  = 0;
      c   = 0;
      lat = 2;
      case (op)
         0: begin p = a + b; f = p & MASK; c = (p > MASK) ? 1 : 0; end
         1: begin f = (a - b) & MASK; c = (a < b) ? 1 : 0; end
         2: begin p = a * b; f = p & MASK; c = ((p >> W) != 0) ? 1 : 0; lat = W + 1; end
         default: begin
            if (b == 0) begin f = 0; dz = 1; end
            else begin f = a / b; lat = W + 1; end
         end
      endcase
      z = (f == 0) ? 1 : 0;
   endfunction

   task automatic set_req(input int id, input int op, input int a, input int b);
      logic [1:0]   op_v;
      logic [W-1:0] a_v;
      logic [W-1:0] b_v;
      op_v = op[1:0];
      a_v  = a[W-1:0];
      b_v  = b[W-1:0];
      req_op[2*id +: 2] = op_v;
      req_a[id*W +: W]  = a_v;
      req_b[id*W +: W]  = b_v;
   endtask

   // Issues one command from a single requester, returns observed response and latency
   task automatic run_cmd(input int id, input int op, input int a, input int b,
                          output int of, output int oc, output int oz, output int odz,
                          output int oid, output int olat, output bit ok);
      int t;
      of = 0; oc = 0; oz = 0; odz = 0; oid = 0; olat = 0; ok = 1'b0;
      @(posedge clk); #1;
      req_op = 4'($urandom);
      req_a  = (2*W)'($urandom);
      req_b  = (2*W)'($urandom);
      set_req(id, op, a, b);
      req_valid = 2'b00;
      req_valid[id] = 1'b1;
      t = 0;
      @(negedge clk);
      while (!req_ready[id] && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready[id]) begin
         req_valid = 2'b00;
         return;
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      do begin
         @(negedge clk);
         olat++;
      end while (!rsp_valid && olat < 40);
      ok  = rsp_valid;
      of  = int'(rsp_f);
      oc  = int'(rsp_carry);
      oz  = int'(rsp_zero);
      odz = int'(rsp_dz);
      oid = int'(rsp_id);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      model_last = id;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 2'b11;
      #12;
      n_checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_f !== '0 ||
          rsp_carry !== 1'b0 || rsp_zero !== 1'b0 || rsp_dz !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: ready=%b valid=%b id=%b f=%h c=%b z=%b dz=%b, required all 0",
                  req_ready, rsp_valid, rsp_id, rsp_f, rsp_carry, rsp_zero, rsp_dz);
      end
      @(negedge clk);
      req_valid = 2'b00;
      rst_n = 1'b1;
      model_last = 1;
      $display("reset: checked outputs during reset");
   endtask

   task automatic test_add_sub();
      int f, c, z, dz, id, lat;
      bit ok;
      run_cmd(0, 0, 'hF0, 'h20, f, c, z, dz, id, lat, ok);
      $display("add r0 F0+20: f=%h c=%0d z=%0d id=%0d lat=%0d", f, c, z, id, lat);
      n_checks++;
      if (!ok || f != 'h10 || c != 1 || z != 0 || dz != 0 || id != 0 || lat != 2) begin
         n_fail++;
         $display("FAIL add_F0_20: f=%h c=%0d z=%0d dz=%0d id=%0d lat=%0d ok=%0d, required f=10 c=1 z=0 dz=0 id=0 lat=2",
                  f, c, z, dz, id, lat, ok);
      end
      run_cmd(1, 1, 5, 5, f, c, z, dz, id, lat, ok);
      $display("sub r1 05-05: f=%h c=%0d z=%0d id=%0d lat=%0d", f, c, z, id, lat);
      n_checks++;
      if (!ok || f != 0 || c != 0 || z != 1 || dz != 0 || id != 1 || lat != 2) begin
         n_fail++;
         $display("FAIL sub_05_05: f=%h c=%0d z=%0d dz=%0d id=%0d lat=%0d, required f=00 c=0 z=1 dz=0 id=1 lat=2",
                  f, c, z, dz, id, lat);
      end
      run_cmd(1, 1, 3, 5, f, c, z, dz, id, lat, ok);
      $display("sub r1 03-05: f=%h c=%0d z=%0d id=%0d lat=%0d", f, c, z, id, lat);
      n_checks++;
      if (!ok || f != 'hFE || c != 1 || z != 0 || dz != 0 || id != 1) begin
         n_fail++;
         $display("FAIL sub_03_05: f=%h c=%0d z=%0d dz=%0d id=%0d, required f=FE c=1 z=0 dz=0 id=1",
                  f, c, z, dz, id);
      end
   endtask

   task automatic test_mul_div();
      int f, c, z, dz, id, lat;
      bit ok;
      run_cmd(0, 2, 'hFF, 'hFF, f, c, z, dz, id, lat, ok);
      $display("mul r0 FF*FF: f=%h c=%0d lat=%0d", f, c, lat);
      n_checks++;
      if (!ok || f != 1 || c != 1 || dz != 0 || lat != 9) begin
         n_fail++;
         $display("FAIL mul_FF_FF: f=%h c=%0d dz=%0d lat=%0d, required f=01 c=1 dz=0 lat=9", f, c, dz, lat);
      end
      run_cmd(1, 3, 200, 7, f, c, z, dz, id, lat, ok);
      $display("div r1 200/7: f=%0d dz=%0d lat=%0d", f, dz, lat);
      n_checks++;
      if (!ok || f != 28 || dz != 0 || c != 0 || lat != 9 || id != 1) begin
         n_fail++;
         $display("FAIL div_200_7: f=%0d dz=%0d c=%0d lat=%0d id=%0d, required f=28 dz=0 c=0 lat=9 id=1",
                  f, dz, c, lat, id);
      end
      run_cmd(0, 3, 'h40, 0, f, c, z, dz, id, lat, ok);
      $display("div r0 40/0: f=%0d dz=%0d c=%0d lat=%0d", f, dz, c, lat);
      n_checks++;
      if (!ok || f != 0 || dz != 1 || c != 0 || lat != 2) begin
         n_fail++;
         $display("FAIL div_by_zero: f=%0d dz=%0d c=%0d lat=%0d, required f=0 dz=1 c=0 lat=2", f, dz, c, lat);
      end
   endtask

   task automatic test_random();
      int f, c, z, dz, id, lat;
      int ef, ec, ez, edz, elat;
      int rid, op, a, b;
      bit ok;
      for (int k = 0; k < 40; k++) begin
         rid = $urandom_range(0, 1);
         op  = $urandom_range(0, 3);
         a   = $urandom_range(0, MASK);
         b   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MASK);
         ref_model(op, a, b, ef, ec, ez, edz, elat);
         run_cmd(rid, op, a, b, f, c, z, dz, id, lat, ok);
         $display("rand %0d: r%0d op=%0d a=%h b=%h -> f=%h c=%0d z=%0d dz=%0d lat=%0d", k, rid, op, a, b, f, c, z, dz, lat);
         n_checks++;
         if (!ok || f != ef || c != ec || z != ez || dz != edz || id != rid || lat != elat) begin
            n_fail++;
            $display("FAIL rand_%0d: f=%h c=%0d z=%0d dz=%0d id=%0d lat=%0d, required f=%h c=%0d z=%0d dz=%0d id=%0d lat=%0d",
                     k, f, c, z, dz, id, lat, ef, ec, ez, edz, rid, elat);
         end
      end
   endtask

   task automatic test_back_to_back();
      int grants[$];
      int ids[$];
      int fs[$];
      int exp_g, t;
      logic [W-1:0] hold_f;
      logic         hold_id, hold_c, hold_z, hold_dz;
      @(posedge clk); #1;
      set_req(0, 0, 1, 0);
      set_req(1, 0, 2, 0);
      rsp_ready = 1'b1;
      req_valid = 2'b11;
      t = 0;
      while (ids.size() < 4 && t < 80) begin
         @(negedge clk);
         t++;
         if (req_ready != 2'b00) grants.push_back(int'(req_ready[1]));
         if (rsp_valid) begin
            ids.push_back(int'(rsp_id));
            fs.push_back(int'(rsp_f));
         end
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      n_checks++;
      if (ids.size() != 4 || grants.size() < 4) begin
         n_fail++;
         $display("FAIL b2b_count: responses=%0d grants=%0d, required 4 each", ids.size(), grants.size());
      end else begin
         exp_g = (model_last == 1) ? 0 : 1;
         for (int k = 0; k < 4; k++) begin
            $display("b2b %0d: grant=%0d rsp_id=%0d f=%0d", k, grants[k], ids[k], fs[k]);
            n_checks++;
            if (grants[k] != exp_g || ids[k] != exp_g || fs[k] != exp_g + 1) begin
               n_fail++;
               $display("FAIL b2b_%0d: grant=%0d id=%0d f=%0d, required grant=%0d id=%0d f=%0d",
                        k, grants[k], ids[k], fs[k], exp_g, exp_g, exp_g + 1);
            end
            exp_g = 1 - exp_g;
         end
         model_last = 1 - exp_g;
      end
      // The 4th handshake is followed by another grant; its response is held back
      exp_g = (model_last == 1) ? 0 : 1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!rsp_valid && t < 40);
      hold_f = rsp_f; hold_id = rsp_id; hold_c = rsp_carry; hold_z = rsp_zero; hold_dz = rsp_dz;
      n_checks++;
      if (!rsp_valid || int'(hold_id) != exp_g || int'(hold_f) != exp_g + 1) begin
         n_fail++;
         $display("FAIL stall_resp: valid=%b id=%0d f=%0d, required valid=1 id=%0d f=%0d",
                  rsp_valid, hold_id, hold_f, exp_g, exp_g + 1);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_f !== hold_f || rsp_id !== hold_id || rsp_carry !== hold_c ||
             rsp_zero !== hold_z || rsp_dz !== hold_dz || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_%0d: valid=%b f=%h id=%b ready=%b, required valid=1 f=%h id=%b ready=00",
                     k, rsp_valid, rsp_f, rsp_id, req_ready, hold_f, hold_id);
         end
      end
      $display("stall: held response id=%0d f=%0d for 5 cycles", hold_id, hold_f);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 2'b00;
      model_last = exp_g;
   endtask

   task automatic test_reset_mid_mul();
      int t;
      @(posedge clk); #1;
      set_req(1, 2, 'hFF, 'hFF);
      req_valid = 2'b10;
      t = 0;
      @(negedge clk);
      while (!req_ready[1] && t < 20) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      set_req(0, 0, 3, 4);
      req_valid = 2'b11;
      #1;
      n_checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_f !== '0 ||
          rsp_carry !== 1'b0 || rsp_zero !== 1'b0 || rsp_dz !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_mul_reset: ready=%b valid=%b id=%b f=%h c=%b z=%b dz=%b, required all 0",
                  req_ready, rsp_valid, rsp_id, rsp_f, rsp_carry, rsp_zero, rsp_dz);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL post_reset_tie: req_ready=%b, required 01", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!rsp_valid && t < 40);
      $display("post-reset: rsp_id=%0d f=%0d lat=%0d", rsp_id, rsp_f, t);
      n_checks++;
      if (!rsp_valid || rsp_id !== 1'b0 || rsp_f !== 8'd7 || t != 2) begin
         n_fail++;
         $display("FAIL post_reset_cmd: valid=%b id=%b f=%0d lat=%0d, required valid=1 id=0 f=7 lat=2",
                  rsp_valid, rsp_id, rsp_f, t);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_mul_div();
      test_random();
      test_back_to_back();
      test_reset_mid_mul();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
